full_subtractor_8: RTL and testbench
====================================

Name: full_subtractor_8

Overview:
8-bit ripple-borrow full subtractor with registered outputs. Computes a - b - carryin; `cout` is the borrow-out. It sits in the datapath as the subtraction primitive for ALU-style blocks. The implementation is a chain of 1-bit full-subtractor cells feeding an output register stage.

Parameters:
WIDTH, 8, operand/result width in bits; ripple chain length equals WIDTH.

Ports:
clk  input  1  single clock; all outputs update on its rising edge
rst  input  1  reset, asynchronous, active-high; clears all output registers
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
carryin  input  1  borrow-in (1 = subtract an extra 1)
sum  output  WIDTH  registered difference (a - b - carryin) mod 2^WIDTH
cout  output  1  registered borrow-out; 1 when a < b + carryin (unsigned)
zero  output  1  registered flag; 1 when the difference is all zeros
ovf  output  1  registered signed-overflow flag for two's-complement interpretation

Behaviour:
- Reset: while rst=1, sum=0, cout=0, zero=0, ovf=0, independent of clk. The register stage clears immediately on assertion.
- After rst deasserts, the first rising clk edge loads the result of the current inputs.
- Datapath:
  - Combinational ripple of WIDTH cells.
  - Cell i: d_i = a_i ^ b_i ^ bin_i; bout_i = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i).
  - bin_0 = carryin; bin_{i+1} = bout_i; cout = bout_{WIDTH-1}.
- Latency: exactly 1 clock. Inputs are sampled on rising edge N and results are visible after edge N; there is no handshake, and a new operation is accepted every cycle.
- Arithmetic rules:
  - sum = (a - b - carryin) mod 2^WIDTH.
  - cout = 1 iff unsigned a < unsigned b + carryin.
  - Borrow-out is NOT an inverted carry; cout=1 means a borrow occurred.
- zero = (difference == 0), computed from the pre-register difference and registered with sum.
- ovf = (a[MSB] != b[MSB]) & (sum[MSB] != a[MSB]), evaluated on the pre-register values. carryin is included via the ripple result.
- Boundaries:
  - a=0, b=0, carryin=1 -> sum=all ones, cout=1.
  - a=all ones, b=0, carryin=0 -> sum=all ones, cout=0.
  - a=b with carryin=1 -> sum=all ones, cout=1, zero=0.
- Reset mid-operation: the in-flight result is discarded and outputs go to 0 asynchronously. A result computed before reset is never presented after it.
- Inputs changing between edges have no effect on outputs until the next rising edge. There are no X outputs once reset has been applied.

Test Plan:
- Assert rst with random a/b -> sum=0x00, cout=0, zero=0, ovf=0 immediately, without waiting for clk. Release rst, apply a=0, b=0, carryin=0 -> after 1 edge sum=0x00, cout=0, zero=1.
- Borrow cases with carryin=0, one result per edge, back-to-back:
  - a=3, b=4 -> sum=0xFF, cout=1.
  - a=2, b=5 -> sum=0xFD, cout=1.
  - a=10, b=15 -> sum=0xFB, cout=1.
- Equal operands: a=9, b=9, carryin=0 -> sum=0x00, cout=0, zero=1. Then carryin=1 -> sum=0xFF, cout=1, zero=0.
- Borrow-in: a=10, b=5, carryin=1 -> sum=0x04, cout=0, ovf=0. Then a=0, b=0, carryin=1 -> sum=0xFF, cout=1.
- Signed overflow:
  - a=0x80, b=0x01, carryin=0 -> sum=0x7F, ovf=1, cout=0.
  - a=0x7F, b=0xFF -> sum=0x80, ovf=1, cout=1.
- Reset mid-stream: drive a=3, b=4 and assert rst between edges -> outputs clear at once. Deassert, apply a=10, b=5, carryin=1 -> next edge sum=0x04. The stale 0xFF never appears.

Source files
------------

// File: rtl/full_subtractor_8.sv
// full_subtractor_8: WIDTH-bit ripple-borrow subtractor (a - b - carryin)
// built from 1-bit full-subtractor cells, with a registered output stage
// carrying the difference, borrow-out, zero and signed-overflow flags.

// One bit of the borrow chain: difference and borrow-out of a - b - bin.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Pure combinational cell; borrow when b (plus borrow-in) exceeds a.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

module full_subtractor_8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned MSB = WIDTH - 1;

  // borrow[i] is the borrow into cell i; borrow[WIDTH] is the final borrow-out.
  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff;
  logic             zero_next;
  logic             ovf_next;

  assign borrow[0] = carryin;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_chain
      full_subtractor_cell u_cell (
        .a    (a[gi]),
        .b    (b[gi]),
        .bin  (borrow[gi]),
        .d    (diff[gi]),
        .bout (borrow[gi+1])
      );
    end
  endgenerate

  // Flags derived from the pre-register difference so they align with sum.
  always_comb begin
    zero_next = (diff == '0);
    ovf_next  = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]);
  end

  // Output register stage; asynchronous reset discards any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      sum  <= diff;
      cout <= borrow[WIDTH];
      zero <= zero_next;
      ovf  <= ovf_next;
    end
  end

endmodule

// File: tb/tb_full_subtractor_8.sv
// Directed testbench for full_subtractor_8 with hand-computed expectations.
module tb_full_subtractor_8;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       carryin;
  logic [7:0] sum;
  logic       cout;
  logic       zero;
  logic       ovf;

  int tests_run;
  int tests_failed;

  full_subtractor_8 #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .carryin (carryin),
    .sum     (sum),
    .cout    (cout),
    .zero    (zero),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive operands away from the edge, then sample just after the next rising edge.
  task automatic apply(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    a = av;
    b = bv;
    carryin = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] s, input logic c,
                            input logic z, input logic o);
    check({tag, ".sum"},  {24'd0, sum}, {24'd0, s});
    check({tag, ".cout"}, {31'd0, cout}, {31'd0, c});
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
    check({tag, ".ovf"},  {31'd0, ovf}, {31'd0, o});
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b0;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    carryin = 1'b1;

    // Asynchronous reset: outputs clear without any clock edge.
    #2;
    rst = 1'b1;
    #1;
    expect_out("reset_async", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    expect_out("reset_held", 8'h00, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    a = 8'd0;
    b = 8'd0;
    carryin = 1'b0;
    @(posedge clk);
    #1;
    expect_out("zero_zero", 8'h00, 1'b0, 1'b1, 1'b0);

    // Back-to-back borrow cases.
    apply(8'd3, 8'd4, 1'b0);
    expect_out("3m4", 8'hFF, 1'b1, 1'b0, 1'b0);
    apply(8'd2, 8'd5, 1'b0);
    expect_out("2m5", 8'hFD, 1'b1, 1'b0, 1'b0);
    apply(8'd10, 8'd15, 1'b0);
    expect_out("10m15", 8'hFB, 1'b1, 1'b0, 1'b0);

    // Equal operands with and without borrow-in.
    apply(8'd9, 8'd9, 1'b0);
    expect_out("9m9", 8'h00, 1'b0, 1'b1, 1'b0);
    apply(8'd9, 8'd9, 1'b1);
    expect_out("9m9b", 8'hFF, 1'b1, 1'b0, 1'b0);

    // Borrow-in.
    apply(8'd10, 8'd5, 1'b1);
    expect_out("10m5b", 8'h04, 1'b0, 1'b0, 1'b0);
    apply(8'd0, 8'd0, 1'b1);
    expect_out("0m0b", 8'hFF, 1'b1, 1'b0, 1'b0);

    // All-ones minus zero.
    apply(8'hFF, 8'h00, 1'b0);
    expect_out("ffm0", 8'hFF, 1'b0, 1'b0, 1'b0);

    // Signed overflow.
    apply(8'h80, 8'h01, 1'b0);
    expect_out("80m01", 8'h7F, 1'b0, 1'b0, 1'b1);
    apply(8'h7F, 8'hFF, 1'b0);
    expect_out("7fmff", 8'h80, 1'b1, 1'b0, 1'b1);

    // Inputs changing between edges must not disturb the registered result.
    @(negedge clk);
    a = 8'd50;
    b = 8'd20;
    carryin = 1'b0;
    #2;
    expect_out("hold_between", 8'h80, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    expect_out("50m20", 8'h1E, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream: in-flight 3-4 result must be discarded.
    @(negedge clk);
    a = 8'd3;
    b = 8'd4;
    carryin = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    expect_out("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    expect_out("rst_mid_edge", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    a = 8'd10;
    b = 8'd5;
    carryin = 1'b1;
    #1;
    expect_out("rst_release", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    expect_out("after_rst", 8'h04, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
